// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fp_pkg
// Purpose  : Shared FP width, quiet-NaN constant and issue FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int              FP_W    = 32;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fpadd_issue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fpadd_issue_fifo
// Purpose  : Synchronous operand-pair FIFO with full/empty flags and count.
// Revision : 1.0 - initial release
// ============================================================================
module fpadd_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Full is decided from the registered count only, so a pop never frees a slot early
    assign full   = (r_count == c_FULL);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/fpadd_issue.sv
`default_nettype none
// ============================================================================
// Module   : fpadd_issue
// Purpose  : Queues FP operand pairs, issues them one at a time to a
//            multi-cycle adder and returns each sum on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module fpadd_issue
    import fp_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_a,
    input  logic [FP_W-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_sum,
    output logic            out_timeout,
    output logic            add_start,
    output logic [FP_W-1:0] add_a,
    output logic [FP_W-1:0] add_b,
    input  logic [FP_W-1:0] add_sum,
    input  logic            add_done,
    output logic            busy
);

    localparam int               c_CW        = $clog2(DEPTH);
    localparam int               c_WDW       = $clog2(TIMEOUT);
    localparam logic [c_WDW-1:0] c_WDOG_LAST = c_WDW'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_add_start;
    logic [FP_W-1:0]   r_add_a;
    logic [FP_W-1:0]   r_add_b;
    logic [c_WDW-1:0]  r_wdog;
    logic              r_out_valid;
    logic [FP_W-1:0]   r_out_sum;
    logic              r_out_timeout;

    logic [2*FP_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic [c_CW:0]     w_count;

    assign w_pop = (r_state == S_IDLE) && !w_empty;

    fpadd_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*FP_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (w_pop),
        .wdata ({in_a, in_b}),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_add_start   <= 1'b0;
            r_add_a       <= '0;
            r_add_b       <= '0;
            r_wdog        <= '0;
            r_out_valid   <= 1'b0;
            r_out_sum     <= '0;
            r_out_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_add_a     <= w_head[2*FP_W-1:FP_W];
                        r_add_b     <= w_head[FP_W-1:0];
                        r_add_start <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_add_start <= 1'b0;
                    r_state     <= S_SETTLE;
                end
                // The adder drops its done on the start edge; skip one cycle so a stale done is never seen
                S_SETTLE: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_wdog <= r_wdog + 1'b1;
                    if (add_done) begin
                        r_out_sum     <= add_sum;
                        r_out_timeout <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_state       <= S_HOLD;
                    end else if (r_wdog == c_WDOG_LAST) begin
                        r_out_sum     <= FP_QNAN;
                        r_out_timeout <= 1'b1;
                        r_out_valid   <= 1'b1;
                        r_state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = !w_full;
    assign out_valid   = r_out_valid;
    assign out_sum     = r_out_sum;
    assign out_timeout = r_out_timeout;
    assign add_start   = r_add_start;
    assign add_a       = r_add_a;
    assign add_b       = r_add_b;
    assign busy        = (w_count != '0) || (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpadd_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpadd_issue
// Purpose  : Self-checking bench for fpadd_issue with a behavioural adder,
//            a timeline reference model and a literal result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fpadd_issue;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready, out_timeout;
    logic        add_start, add_done, busy;
    logic [31:0] in_a, in_b, out_sum, add_a, add_b, add_sum;

    int tests_run    = 0;
    int tests_failed = 0;
    int n_starts     = 0;
    int n_results    = 0;

    fpadd_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_timeout (out_timeout),
        .add_start   (add_start),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_sum     (add_sum),
        .add_done    (add_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Behavioural adder: done is a level that drops on start (or one cycle later in stale mode)
    int          adder_lat    = 2;
    bit          adder_hang   = 1'b0;
    bit          stale_mode   = 1'b0;
    bit          stale_pend   = 1'b0;
    int          ad_cnt       = -1;
    logic [31:0] ad_res       = '0;
    logic [31:0] ad_q[$];

    initial begin
        add_done = 1'b0;
        add_sum  = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                add_done   = 1'b0;
                ad_cnt     = -1;
                stale_pend = 1'b0;
            end else begin
                if (stale_pend) begin
                    add_done   = 1'b0;
                    stale_pend = 1'b0;
                end
                if (add_start) begin
                    if (stale_mode) stale_pend = 1'b1;
                    else            add_done   = 1'b0;
                    ad_cnt = 0;
                    ad_res = (ad_q.size() > 0) ? ad_q.pop_front() : 32'hDEAD_BEEF;
                end else if (ad_cnt >= 0) begin
                    ad_cnt++;
                    if (ad_cnt == adder_lat && !adder_hang) begin
                        add_done = 1'b1;
                        add_sum  = ad_res;
                        ad_cnt   = -1;
                    end
                end
            end
        end
    end

    // Reference model on a timeline: cycles elapsed since the pop edge decide start/ignore/wait
    logic [63:0] mq[$];
    bit          m_op = 1'b0, m_hold = 1'b0, m_can_push;
    int          m_pop_edge = 0, n_edge = 0, m_d;
    logic [31:0] m_a = '0, m_b = '0, m_sum = '0;
    logic        m_to = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_op = 1'b0; m_hold = 1'b0;
            m_a = '0; m_b = '0; m_sum = '0; m_to = 1'b0;
        end else begin
            m_can_push = in_valid && (mq.size() != DEPTH);
            n_edge++;
            if (m_op) begin
                m_d = n_edge - m_pop_edge;
                if (m_d >= 3) begin
                    if (add_done) begin
                        m_sum = add_sum; m_to = 1'b0; m_op = 1'b0; m_hold = 1'b1;
                    end else if (m_d - 3 == TIMEOUT - 1) begin
                        m_sum = 32'h7FC0_0000; m_to = 1'b1; m_op = 1'b0; m_hold = 1'b1;
                    end
                end
            end else if (m_hold) begin
                if (out_ready) m_hold = 1'b0;
            end else if (mq.size() > 0) begin
                {m_a, m_b} = mq.pop_front();
                m_op       = 1'b1;
                m_pop_edge = n_edge;
            end
            if (m_can_push) mq.push_back({in_a, in_b});
        end
    end

    // Hand-computed results in push order: {timeout, sum}
    logic [32:0] exp_q[$];
    logic [32:0] exp_e;

    always @(negedge clk) begin
        chk("in_ready",  {31'd0, in_ready},  {31'd0, mq.size() != DEPTH});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
        chk("add_start", {31'd0, add_start}, {31'd0, m_op && (m_pop_edge == n_edge)});
        chk("busy",      {31'd0, busy},      {31'd0, (mq.size() != 0) || m_op || m_hold});
        chk("add_a", add_a, m_a);
        chk("add_b", add_b, m_b);
        if (m_hold) begin
            chk("out_sum",     out_sum, m_sum);
            chk("out_timeout", {31'd0, out_timeout}, {31'd0, m_to});
        end
        if (add_start) n_starts++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("result_extra", out_sum, 32'hFFFF_FFFF);
            end else begin
                exp_e = exp_q.pop_front();
                chk("result_sum", out_sum, exp_e[31:0]);
                chk("result_to", {31'd0, out_timeout}, {31'd0, exp_e[32]});
            end
            n_results++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        bit acc;
        int w;
        in_valid = 1'b1; in_a = a; in_b = b;
        w = 0;
        do begin
            acc = in_ready;
            tick();
            w++;
        end while (!acc && w < 300);
        chk("push_accepted", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic expect_op(input logic [31:0] sum, input bit to, input bit to_adder);
        exp_q.push_back({to, sum});
        if (to_adder) ad_q.push_back(sum);
    endtask

    task automatic wait_valid(input string nm);
        int w;
        w = 0;
        while (!out_valid && w < 300) begin tick(); w++; end
        chk(nm, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_results(input int k, input string nm);
        int w;
        w = 0;
        while (n_results < k && w < 600) begin tick(); w++; end
        chk(nm, n_results, k);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end

    int s0, cnt, w;

    initial begin
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_add_start", {31'd0, add_start}, 32'd0);
        chk("rst_out_sum",   out_sum, 32'd0);
        reset = 1'b1;
        tick();

        // Single pair 1.0 + 2.0 with a 6-cycle adder
        adder_lat = 6;
        expect_op(32'h4040_0000, 1'b0, 1'b1);
        s0 = n_starts;
        push(32'h3F80_0000, 32'h4000_0000);
        wait_valid("t1_valid");
        repeat (5) tick();
        chk("t1_starts", n_starts - s0, 32'd1);
        chk("t1_add_a", add_a, 32'h3F80_0000);
        chk("t1_add_b", add_b, 32'h4000_0000);
        chk("t1_sum", out_sum, 32'h4040_0000);
        chk("t1_timeout", {31'd0, out_timeout}, 32'd0);
        chk("t1_held", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        wait_results(1, "t1_results");

        // Fill: five back-to-back pushes, one pops straight away
        adder_lat = 2;
        out_ready = 1'b1;
        expect_op(32'h4000_0000, 1'b0, 1'b1);
        expect_op(32'h4080_0000, 1'b0, 1'b1);
        expect_op(32'h4080_0000, 1'b0, 1'b1);
        expect_op(32'h3F80_0000, 1'b0, 1'b1);
        expect_op(32'h4100_0000, 1'b0, 1'b1);
        push(32'h3F80_0000, 32'h3F80_0000);
        push(32'h4000_0000, 32'h4000_0000);
        push(32'h3F80_0000, 32'h4040_0000);
        push(32'h3F00_0000, 32'h3F00_0000);
        push(32'h4080_0000, 32'h4080_0000);
        chk("t2_full", {31'd0, in_ready}, 32'd0);
        wait_results(6, "t2_results");

        // Backpressure: result held 20 cycles, no new issue, then issue two cycles after release
        out_ready = 1'b0;
        expect_op(32'h4000_0000, 1'b0, 1'b1);
        expect_op(32'h4080_0000, 1'b0, 1'b1);
        push(32'h3F80_0000, 32'h3F80_0000);
        push(32'h4040_0000, 32'h3F80_0000);
        wait_valid("t3_valid");
        s0 = n_starts;
        repeat (20) tick();
        chk("t3_no_start", n_starts - s0, 32'd0);
        chk("t3_sum", out_sum, 32'h4000_0000);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("t3_gap", {31'd0, add_start}, 32'd0);
        tick();
        chk("t3_issue", {31'd0, add_start}, 32'd1);
        out_ready = 1'b1;
        wait_results(8, "t3_results");

        // Stale done: previous done held through ISSUE, new done arrives 3 cycles after start
        stale_mode = 1'b1;
        adder_lat  = 3;
        expect_op(32'h40A0_0000, 1'b0, 1'b1);
        expect_op(32'h4110_0000, 1'b0, 1'b1);
        push(32'h4000_0000, 32'h4040_0000);
        push(32'h4100_0000, 32'h3F80_0000);
        wait_results(10, "t4_results");
        stale_mode = 1'b0;

        // Watchdog: adder never finishes
        adder_hang = 1'b1;
        adder_lat  = 2;
        out_ready  = 1'b0;
        expect_op(32'h7FC0_0000, 1'b1, 1'b0);
        push(32'h3F80_0000, 32'h3F80_0000);
        w = 0;
        while (!add_start && w < 50) begin tick(); w++; end
        chk("t5_start", {31'd0, add_start}, 32'd1);
        cnt = 0;
        while (!out_valid && cnt < 300) begin tick(); cnt++; end
        chk("t5_latency", cnt, TIMEOUT + 2);
        chk("t5_sum", out_sum, 32'h7FC0_0000);
        chk("t5_timeout", {31'd0, out_timeout}, 32'd1);
        adder_hang = 1'b0;
        expect_op(32'h3FC0_0000, 1'b0, 1'b1);
        out_ready = 1'b1;
        push(32'h3F00_0000, 32'h3F80_0000);
        wait_results(12, "t5_results");

        // Async reset mid-WAIT with three pairs queued
        adder_hang = 1'b1;
        out_ready  = 1'b0;
        push(32'h3F80_0000, 32'h3F80_0000);
        push(32'h4000_0000, 32'h4000_0000);
        push(32'h4040_0000, 32'h4040_0000);
        push(32'h4080_0000, 32'h4080_0000);
        repeat (4) tick();
        #2 reset = 1'b0;
        #1;
        chk("t6_add_start", {31'd0, add_start}, 32'd0);
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_busy",      {31'd0, busy},      32'd0);
        chk("t6_in_ready",  {31'd0, in_ready},  32'd1);
        chk("t6_add_a",     add_a, 32'd0);
        chk("t6_out_sum",   out_sum, 32'd0);
        exp_q.delete();
        ad_q.delete();
        adder_hang = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        s0 = n_starts;
        repeat (10) tick();
        chk("t6_no_start", n_starts - s0, 32'd0);
        chk("t6_idle_busy", {31'd0, busy}, 32'd0);
        out_ready = 1'b1;
        expect_op(32'h4100_0000, 1'b0, 1'b1);
        push(32'h4080_0000, 32'h4080_0000);
        wait_results(13, "t6_results");

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
